// File: rtl/uart_bus_sequencer_pkg.sv
// Shared types and constants for the UART-to-data-port command sequencer.
package uart_bus_sequencer_pkg;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_GET_ADDR  = 4'd1,
    ST_GET_DATA  = 4'd2,
    ST_WR_SETUP  = 4'd3,
    ST_WR_STROBE = 4'd4,
    ST_WR_HOLD   = 4'd5,
    ST_RD_SETUP  = 4'd6,
    ST_RD_STROBE = 4'd7,
    ST_TX_WAIT   = 4'd8
  } state_t;

  // Latched command type
  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h4B;

endpackage

// File: rtl/uart_bus_sequencer.sv
// Command sequencer between the UART byte interface and the external 8-bit
// data port. Parses 'W' addr data / 'R' addr commands, runs timed strobe
// cycles, and replies with an ack byte or the read byte.
// Ports:
//   SYSCLK, NSYSRESET         clock, async active-low reset
//   rx_data/rx_valid          received byte from UART core
//   tx_data/tx_start/tx_busy  byte to transmit, start pulse, transmitter busy
//   bus_addr/bus_wr_n/bus_rd_n external address and active-low strobes
//   data_out/data_oe/data_in  pad write data, output enable, pad input
//   busy                      high whenever not idle
//   err_cnt                   saturating error counter
module uart_bus_sequencer
  import uart_bus_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              SYSCLK,
  input  logic              NSYSRESET,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wr_n,
  output logic              bus_rd_n,
  output logic [7:0]        data_out,
  output logic              data_oe,
  input  logic [7:0]        data_in,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYC > STROBE_CYC) ? TIMEOUT_CYC : STROBE_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state, state_nxt;
  op_t                 op, op_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                err_evt;
  logic [7:0]          tx_data_nxt;
  logic                tx_start_nxt;
  logic [ADDR_W-1:0]   bus_addr_nxt;
  logic [7:0]          data_out_nxt;
  logic [7:0]          err_cnt_nxt;
  logic                bus_wr_n_nxt, bus_rd_n_nxt, data_oe_nxt, busy_nxt;

  // State and registered outputs
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state    <= ST_IDLE;
      op       <= OP_WR;
      cnt      <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      bus_addr <= '0;
      bus_wr_n <= 1'b1;
      bus_rd_n <= 1'b1;
      data_out <= '0;
      data_oe  <= 1'b0;
      busy     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      op       <= op_nxt;
      cnt      <= cnt_nxt;
      tx_data  <= tx_data_nxt;
      tx_start <= tx_start_nxt;
      bus_addr <= bus_addr_nxt;
      bus_wr_n <= bus_wr_n_nxt;
      bus_rd_n <= bus_rd_n_nxt;
      data_out <= data_out_nxt;
      data_oe  <= data_oe_nxt;
      busy     <= busy_nxt;
      err_cnt  <= err_cnt_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    op_nxt       = op;
    cnt_nxt      = cnt;
    err_evt      = 1'b0;
    tx_data_nxt  = tx_data;
    tx_start_nxt = 1'b0;
    bus_addr_nxt = bus_addr;
    data_out_nxt = data_out;

    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WR) begin
            op_nxt    = OP_WR;
            cnt_nxt   = '0;
            state_nxt = ST_GET_ADDR;
          end else if (rx_data == CMD_RD) begin
            op_nxt    = OP_RD;
            cnt_nxt   = '0;
            state_nxt = ST_GET_ADDR;
          end else begin
            err_evt = 1'b1;
          end
        end
      end
      ST_GET_ADDR: begin
        if (rx_valid) begin
          bus_addr_nxt = ADDR_W'(rx_data);
          cnt_nxt      = '0;
          state_nxt    = (op == OP_WR) ? ST_GET_DATA : ST_RD_SETUP;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_evt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_GET_DATA: begin
        if (rx_valid) begin
          data_out_nxt = rx_data;
          cnt_nxt      = '0;
          state_nxt    = ST_WR_SETUP;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_evt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_WR_SETUP: begin
        cnt_nxt   = '0;
        state_nxt = ST_WR_STROBE;
      end
      ST_WR_STROBE: begin
        if (cnt == CNT_W'(STROBE_CYC - 1)) state_nxt = ST_WR_HOLD;
        else                               cnt_nxt   = cnt + CNT_W'(1);
      end
      ST_WR_HOLD: begin
        tx_data_nxt = ACK;
        state_nxt   = ST_TX_WAIT;
      end
      ST_RD_SETUP: begin
        cnt_nxt   = '0;
        state_nxt = ST_RD_STROBE;
      end
      ST_RD_STROBE: begin
        // Sample the pad on the last strobe cycle, while bus_rd_n is still low
        if (cnt == CNT_W'(STROBE_CYC - 1)) begin
          tx_data_nxt = data_in;
          state_nxt   = ST_TX_WAIT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_TX_WAIT: begin
        if (!tx_busy) begin
          tx_start_nxt = 1'b1;
          state_nxt    = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Bytes arriving while the bus cycle or reply is in progress are dropped
    if (rx_valid && (state inside {ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD,
                                   ST_RD_SETUP, ST_RD_STROBE, ST_TX_WAIT}))
      err_evt = 1'b1;

    err_cnt_nxt = (err_evt && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;

    // Pad controls follow the state being entered so they line up with it
    bus_wr_n_nxt = (state_nxt != ST_WR_STROBE);
    bus_rd_n_nxt = (state_nxt != ST_RD_STROBE);
    data_oe_nxt  = (state_nxt inside {ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD});
    busy_nxt     = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// Self-checking bench for uart_bus_sequencer.
module tb_uart_bus_sequencer;

  localparam int unsigned ADDR_W = 8;

  logic              SYSCLK = 1'b0;
  logic              NSYSRESET;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_wr_n;
  logic              bus_rd_n;
  logic [7:0]        data_out;
  logic              data_oe;
  logic [7:0]        data_in;
  logic              busy;
  logic [7:0]        err_cnt;

  uart_bus_sequencer #(
    .ADDR_W(ADDR_W), .STROBE_CYC(4), .TIMEOUT_CYC(50)
  ) dut (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .bus_addr(bus_addr), .bus_wr_n(bus_wr_n), .bus_rd_n(bus_rd_n),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #50 SYSCLK = ~SYSCLK;

  int checks = 0;
  int errors = 0;

  // Cumulative activity monitor
  int       wr_low = 0, rd_low = 0, oe_hi = 0, clash = 0, tx_cnt = 0;
  logic [7:0] tx_last = 8'h00;
  always @(posedge SYSCLK) begin
    if (!bus_wr_n) wr_low <= wr_low + 1;
    if (!bus_rd_n) rd_low <= rd_low + 1;
    if (data_oe) oe_hi <= oe_hi + 1;
    if (data_oe && !bus_rd_n) clash <= clash + 1;
    if (tx_start) begin
      tx_cnt  <= tx_cnt + 1;
      tx_last <= tx_data;
    end
  end

  typedef struct {
    logic       is_wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] din;
    logic [7:0] exp_tx;
    int         exp_wr_low;
    int         exp_rd_low;
    int         exp_oe;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge SYSCLK);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge SYSCLK);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int snap, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge SYSCLK);
      if (tx_cnt != snap) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge SYSCLK);
  endtask

  vec_t vecs[4];
  int   s_wr, s_rd, s_oe, s_tx;
  bit   ok;

  initial begin
    vecs[0] = '{1'b1, 8'h12, 8'hA5, 8'h00, 8'h4B, 4, 0, 6};
    vecs[1] = '{1'b0, 8'h34, 8'h00, 8'h5C, 8'h5C, 0, 4, 0};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'h33, 8'h4B, 4, 0, 6};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, 4, 0};

    NSYSRESET = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    tx_busy   = 1'b0;
    data_in   = 8'h00;
    idle(3);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_bus_addr", int'(bus_addr), 0);
    chk("rst_bus_wr_n", int'(bus_wr_n), 1);
    chk("rst_bus_rd_n", int'(bus_rd_n), 1);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_data_oe", int'(data_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    NSYSRESET = 1'b1;
    idle(2);

    // Table-driven write/read transactions
    for (int v = 0; v < 4; v++) begin
      s_wr = wr_low; s_rd = rd_low; s_oe = oe_hi; s_tx = tx_cnt;
      data_in = vecs[v].din;
      send_byte(vecs[v].is_wr ? 8'h57 : 8'h52);
      send_byte(vecs[v].addr);
      if (vecs[v].is_wr) send_byte(vecs[v].wdata);
      chk($sformatf("v%0d_busy", v), int'(busy), 1);
      wait_tx(s_tx, ok);
      chk($sformatf("v%0d_tx_seen", v), int'(ok), 1);
      idle(3);
      chk($sformatf("v%0d_tx_count", v), tx_cnt - s_tx, 1);
      chk($sformatf("v%0d_tx_data", v), int'(tx_last), int'(vecs[v].exp_tx));
      chk($sformatf("v%0d_wr_low", v), wr_low - s_wr, vecs[v].exp_wr_low);
      chk($sformatf("v%0d_rd_low", v), rd_low - s_rd, vecs[v].exp_rd_low);
      chk($sformatf("v%0d_oe_cycles", v), oe_hi - s_oe, vecs[v].exp_oe);
      chk($sformatf("v%0d_bus_addr", v), int'(bus_addr), int'(vecs[v].addr));
      if (vecs[v].is_wr) chk($sformatf("v%0d_data_out", v), int'(data_out), int'(vecs[v].wdata));
      chk($sformatf("v%0d_busy_end", v), int'(busy), 0);
      chk($sformatf("v%0d_err", v), int'(err_cnt), 0);
    end

    // Unknown command byte
    s_wr = wr_low; s_rd = rd_low; s_tx = tx_cnt;
    send_byte(8'h41);
    idle(2);
    chk("unk_err", int'(err_cnt), 1);
    chk("unk_busy", int'(busy), 0);
    chk("unk_bus", (wr_low - s_wr) + (rd_low - s_rd) + (tx_cnt - s_tx), 0);

    // Timeout while waiting for the address byte
    s_tx = tx_cnt;
    send_byte(8'h57);
    idle(45);
    chk("to_busy_before", int'(busy), 1);
    idle(10);
    chk("to_busy_after", int'(busy), 0);
    chk("to_err", int'(err_cnt), 2);
    chk("to_no_tx", tx_cnt - s_tx, 0);

    // TX backpressure on a read
    tx_busy = 1'b1;
    data_in = 8'hC3;
    s_tx = tx_cnt;
    send_byte(8'h52);
    send_byte(8'h66);
    idle(26);
    chk("bp_no_tx", tx_cnt - s_tx, 0);
    chk("bp_busy", int'(busy), 1);
    tx_busy = 1'b0;
    @(negedge SYSCLK);
    chk("bp_pulse", int'(tx_start), 1);
    chk("bp_pulse_data", int'(tx_data), 8'hC3);
    @(negedge SYSCLK);
    chk("bp_pulse_end", int'(tx_start), 0);
    idle(3);
    chk("bp_tx_count", tx_cnt - s_tx, 1);

    // Overrun during the write strobe
    s_wr = wr_low; s_tx = tx_cnt;
    send_byte(8'h57);
    send_byte(8'h20);
    send_byte(8'h77);
    @(negedge SYSCLK);
    send_byte(8'h99);
    wait_tx(s_tx, ok);
    chk("ovr_tx_seen", int'(ok), 1);
    idle(3);
    chk("ovr_tx_data", int'(tx_last), 8'h4B);
    chk("ovr_wr_low", wr_low - s_wr, 4);
    chk("ovr_addr", int'(bus_addr), 8'h20);
    chk("ovr_data", int'(data_out), 8'h77);
    chk("ovr_err", int'(err_cnt), 3);

    // Reset in the middle of a read strobe
    s_tx = tx_cnt;
    send_byte(8'h52);
    send_byte(8'h40);
    idle(2);
    chk("mr_rd_active", int'(bus_rd_n), 0);
    NSYSRESET = 1'b0;
    #1;
    chk("mr_rd_n", int'(bus_rd_n), 1);
    chk("mr_busy", int'(busy), 0);
    chk("mr_oe", int'(data_oe), 0);
    chk("mr_err", int'(err_cnt), 0);
    @(negedge SYSCLK);
    NSYSRESET = 1'b1;
    idle(20);
    chk("mr_no_tx", tx_cnt - s_tx, 0);
    chk("mr_busy_after", int'(busy), 0);

    // Error counter saturation
    for (int i = 0; i < 300; i++) send_byte(8'h00);
    idle(2);
    chk("sat_err", int'(err_cnt), 8'hFF);

    chk("oe_rd_clash", clash, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
